// File: rtl/ipv4_proto_demux_if.sv
// Byte-stream bus of ipv4_proto_demux.
// Upstream FWFT packet input plus NUM_CH FWFT channel outputs.
interface ipv4_proto_demux_if #(
  parameter int NUM_CH = 2
) ();
  logic [7:0]          i_ipv4_pkt_byte;
  logic                i_ipv4_pkt_byte_vld;
  logic                i_ipv4_pkt_last_byte;
  logic                o_ipv4_pkt_byte_rd;
  logic [NUM_CH*8-1:0] o_ch_byte;
  logic [NUM_CH-1:0]   o_ch_byte_vld;
  logic [NUM_CH-1:0]   o_ch_last_byte;
  logic [NUM_CH-1:0]   i_ch_byte_rd;

  modport slave (
    input  i_ipv4_pkt_byte,
    input  i_ipv4_pkt_byte_vld,
    input  i_ipv4_pkt_last_byte,
    output o_ipv4_pkt_byte_rd,
    output o_ch_byte,
    output o_ch_byte_vld,
    output o_ch_last_byte,
    input  i_ch_byte_rd
  );

  modport master (
    output i_ipv4_pkt_byte,
    output i_ipv4_pkt_byte_vld,
    output i_ipv4_pkt_last_byte,
    input  o_ipv4_pkt_byte_rd,
    input  o_ch_byte,
    input  o_ch_byte_vld,
    input  o_ch_last_byte,
    output i_ch_byte_rd
  );
endinterface

// File: rtl/ipv4_proto_demux.sv
// IPv4 protocol demux: parses IHL/protocol and routes
// packets into per-channel {last,byte} FWFT FIFOs.
module ipv4_proto_demux #(
  parameter int NUM_CH = 2,
  parameter logic [NUM_CH*8-1:0] CH_PROTOS =
    {8'h11, 8'h01},
  parameter int KEEP_HDR = 0,
  parameter int MAX_PKT_BYTES = 1500,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic              i_rxmac_clk,
  input  logic              i_rxmac_srst,
  ipv4_proto_demux_if.slave bus,
  output logic [NUM_CH-1:0] o_fifo_overflow,
  output logic              o_unsupported_proto,
  output logic              o_malformed_hdr,
  output logic [15:0]       o_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_HWR,
    S_ROUTE,
    S_DROP
  } state_t;

  state_t       state;
  logic         rd_q;
  logic [5:0]   cnt;
  logic [3:0]   ihl;
  logic [5:0]   hdr_end;
  logic [CW-1:0] sel;
  logic [5:0]   hwr_idx;
  logic [7:0]   hdr_buf [60];

  logic         wr_vld;
  logic [CW-1:0] wr_ch;
  logic [8:0]   wr_dat;

  logic [AW:0]  fill [NUM_CH];
  logic [AW:0]  free_sel;
  logic         space_ok;
  logic         take;
  logic         last;
  logic [7:0]   din;
  logic         hit;
  logic [CW-1:0] hit_ch;

  assign din  = bus.i_ipv4_pkt_byte;
  assign last = bus.i_ipv4_pkt_last_byte;
  assign take = rd_q & bus.i_ipv4_pkt_byte_vld;
  assign bus.o_ipv4_pkt_byte_rd = rd_q;

  assign hdr_end  = {ihl, 2'b00} - 6'd1;
  assign free_sel = (AW+1)'(FIFO_DEPTH) - fill[sel];
  assign space_ok =
    free_sel >= (AW+1)'(MAX_PKT_BYTES);

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Protocol lookup; scanning downward lets the lowest
  // matching channel win.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (CH_PROTOS[8*k +: 8] == din) begin
        hit    = 1'b1;
        hit_ch = CW'(k);
      end
    end
  end

  // Capture header bytes for replay when keeping the header.
  always_ff @(posedge i_rxmac_clk) begin
    if (state == S_HDR && take)
      hdr_buf[cnt] <= din;
  end

  // Packet FSM: parse, space check, route or drain.
  always_ff @(posedge i_rxmac_clk) begin
    if (i_rxmac_srst) begin
      state               <= S_IDLE;
      rd_q                <= 1'b0;
      cnt                 <= '0;
      ihl                 <= '0;
      sel                 <= '0;
      hwr_idx             <= '0;
      wr_vld              <= 1'b0;
      wr_ch               <= '0;
      wr_dat              <= '0;
      o_unsupported_proto <= 1'b0;
      o_malformed_hdr     <= 1'b0;
      o_drop_cnt          <= '0;
    end else begin
      o_unsupported_proto <= 1'b0;
      o_malformed_hdr     <= 1'b0;
      wr_vld              <= 1'b0;
      if (|o_fifo_overflow) begin
        state <= S_IDLE;
        rd_q  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            cnt <= '0;
            if (bus.i_ipv4_pkt_byte_vld) begin
              state <= S_HDR;
              rd_q  <= 1'b1;
            end
          end
          S_HDR: if (take) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd0) begin
              ihl <= din[3:0];
              if (din[3:0] < 4'd5) begin
                o_malformed_hdr <= 1'b1;
                if (last) begin
                  o_drop_cnt <= sat_inc(o_drop_cnt);
                  rd_q       <= 1'b0;
                  state      <= S_IDLE;
                end else begin
                  state <= S_DROP;
                end
              end
            end else if (cnt == 6'd9) begin
              sel <= hit_ch;
              if (!hit) begin
                o_unsupported_proto <= 1'b1;
                if (last) begin
                  o_drop_cnt <= sat_inc(o_drop_cnt);
                  rd_q       <= 1'b0;
                  state      <= S_IDLE;
                end else begin
                  state <= S_DROP;
                end
              end else if (last) begin
                o_malformed_hdr <= 1'b1;
                o_drop_cnt      <= sat_inc(o_drop_cnt);
                rd_q            <= 1'b0;
                state           <= S_IDLE;
              end
            end else if (cnt == hdr_end) begin
              if (last) begin
                o_malformed_hdr <= 1'b1;
                o_drop_cnt      <= sat_inc(o_drop_cnt);
                rd_q            <= 1'b0;
                state           <= S_IDLE;
              end else if (KEEP_HDR != 0) begin
                rd_q    <= 1'b0;
                hwr_idx <= '0;
                state   <= space_ok ? S_HWR : S_WAIT;
              end else if (space_ok) begin
                state <= S_ROUTE;
              end else begin
                rd_q  <= 1'b0;
                state <= S_WAIT;
              end
            end else if (last) begin
              o_malformed_hdr <= 1'b1;
              o_drop_cnt      <= sat_inc(o_drop_cnt);
              rd_q            <= 1'b0;
              state           <= S_IDLE;
            end
          end
          S_WAIT: if (space_ok) begin
            if (KEEP_HDR != 0) begin
              hwr_idx <= '0;
              state   <= S_HWR;
            end else begin
              rd_q  <= 1'b1;
              state <= S_ROUTE;
            end
          end
          S_HWR: begin
            wr_vld  <= 1'b1;
            wr_ch   <= sel;
            wr_dat  <= {1'b0, hdr_buf[hwr_idx]};
            hwr_idx <= hwr_idx + 6'd1;
            if (hwr_idx == hdr_end) begin
              rd_q  <= 1'b1;
              state <= S_ROUTE;
            end
          end
          S_ROUTE: if (take) begin
            wr_vld <= 1'b1;
            wr_ch  <= sel;
            wr_dat <= {last, din};
            if (last) begin
              rd_q  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_DROP: if (take && last) begin
            o_drop_cnt <= sat_inc(o_drop_cnt);
            rd_q       <= 1'b0;
            state      <= S_IDLE;
          end
          default: begin
            rd_q  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        full;
    logic        empty;
    logic        we;
    logic        re;
    logic        ovf;
    logic [8:0]  head;

    assign full  = (wp - rp) == (AW+1)'(FIFO_DEPTH);
    assign empty = (wp == rp);
    assign we    = wr_vld && (wr_ch == CW'(k));
    assign re    = bus.i_ch_byte_rd[k] && !empty;
    assign head  = mem[rp[AW-1:0]];

    assign fill[k]               = wp - rp;
    assign o_fifo_overflow[k]    = ovf;
    assign bus.o_ch_byte_vld[k]  = !empty;
    assign bus.o_ch_last_byte[k] = !empty && head[8];
    assign bus.o_ch_byte[8*k +: 8] =
      empty ? 8'h00 : head[7:0];

    // Storage write; a write into a full FIFO is discarded.
    always_ff @(posedge i_rxmac_clk) begin
      if (we && !full)
        mem[wp[AW-1:0]] <= wr_dat;
    end

    // Pointers and sticky overflow flag.
    always_ff @(posedge i_rxmac_clk) begin
      if (i_rxmac_srst) begin
        wp  <= '0;
        rp  <= '0;
        ovf <= 1'b0;
      end else begin
        if (we && !full)
          wp <= wp + 1'b1;
        if (we && full)
          ovf <= 1'b1;
        if (re)
          rp <= rp + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ipv4_proto_demux.sv
// Self-checking bench for ipv4_proto_demux.
// Scoreboard queues hold expected {last,byte} per channel.
module tb_ipv4_proto_demux;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  ipv4_proto_demux_if #(.NUM_CH(2)) b0 ();
  ipv4_proto_demux_if #(.NUM_CH(2)) b1 ();

  logic [1:0]  ovf0, ovf1;
  logic        uns0, mal0, uns1, mal1;
  logic [15:0] drop0, drop1;

  ipv4_proto_demux #(
    .NUM_CH(2),
    .CH_PROTOS({8'h01, 8'h11}),
    .KEEP_HDR(0),
    .MAX_PKT_BYTES(1500),
    .FIFO_DEPTH(2048)
  ) dut0 (
    .i_rxmac_clk(clk),
    .i_rxmac_srst(srst),
    .bus(b0),
    .o_fifo_overflow(ovf0),
    .o_unsupported_proto(uns0),
    .o_malformed_hdr(mal0),
    .o_drop_cnt(drop0)
  );

  ipv4_proto_demux #(
    .NUM_CH(2),
    .CH_PROTOS({8'h01, 8'h11}),
    .KEEP_HDR(1),
    .MAX_PKT_BYTES(1500),
    .FIFO_DEPTH(2048)
  ) dut1 (
    .i_rxmac_clk(clk),
    .i_rxmac_srst(srst),
    .bus(b1),
    .o_fifo_overflow(ovf1),
    .o_unsupported_proto(uns1),
    .o_malformed_hdr(mal1),
    .o_drop_cnt(drop1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mal_n = 0;
  int uns_n = 0;
  int both_n = 0;

  logic [7:0] pkt [$];
  logic [8:0] q00 [$];
  logic [8:0] q01 [$];
  logic [8:0] q11 [$];
  int send_idx = 0;
  int sent_cnt = 0;
  int mark_idx = -1;
  int mark_cyc = 0;
  bit abort_tx = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mal0) mal_n <= mal_n + 1;
    if (uns0) uns_n <= uns_n + 1;
    if ((mal0 && uns0) || (mal1 && uns1))
      both_n <= both_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic build(input logic [7:0] proto,
                       input int ihl, input int total);
    logic [3:0] ih;
    ih = 4'(ihl);
    pkt.delete();
    for (int i = 0; i < total; i++) begin
      if (i == 0) pkt.push_back({4'h4, ih});
      else if (i == 9) pkt.push_back(proto);
      else pkt.push_back(8'($urandom));
    end
  endtask

  task automatic push_exp(input int d, input int ch,
                          input logic [8:0] v);
    if (d == 0 && ch == 0) q00.push_back(v);
    else if (d == 0) q01.push_back(v);
    else q11.push_back(v);
  endtask

  function automatic logic [9:0] pop_exp(input int d,
                                         input int ch);
    logic [9:0] r;
    r = '0;
    if (d == 0 && ch == 0) begin
      if (q00.size() > 0) r = {1'b1, q00.pop_front()};
    end else if (d == 0) begin
      if (q01.size() > 0) r = {1'b1, q01.pop_front()};
    end else begin
      if (q11.size() > 0) r = {1'b1, q11.pop_front()};
    end
    return r;
  endfunction

  task automatic expect_pkt(input int d, input int ch,
                            input int start);
    int n;
    n = pkt.size();
    for (int i = start; i < n; i++)
      push_exp(d, ch, {i == n - 1, pkt[i]});
  endtask

  task automatic send(input int d, input int budget);
    int i;
    int t;
    int n;
    logic rd_now;
    i = 0;
    t = 0;
    n = pkt.size();
    send_idx = 0;
    while (i < n && !abort_tx) begin
      @(negedge clk);
      if (d == 0) begin
        b0.i_ipv4_pkt_byte      = pkt[i];
        b0.i_ipv4_pkt_byte_vld  = 1'b1;
        b0.i_ipv4_pkt_last_byte = (i == n - 1);
        rd_now = b0.o_ipv4_pkt_byte_rd;
      end else begin
        b1.i_ipv4_pkt_byte      = pkt[i];
        b1.i_ipv4_pkt_byte_vld  = 1'b1;
        b1.i_ipv4_pkt_last_byte = (i == n - 1);
        rd_now = b1.o_ipv4_pkt_byte_rd;
      end
      if (rd_now) begin
        if (i == mark_idx) mark_cyc = cyc;
        i++;
      end
      send_idx = i;
      t++;
      if (t > budget) begin
        checks++;
        errors++;
        $display("FAIL send_timeout d%0d: idx %0d want %0d",
                 d, i, n);
        break;
      end
    end
    @(negedge clk);
    b0.i_ipv4_pkt_byte_vld  = 1'b0;
    b0.i_ipv4_pkt_last_byte = 1'b0;
    b1.i_ipv4_pkt_byte_vld  = 1'b0;
    b1.i_ipv4_pkt_last_byte = 1'b0;
  endtask

  task automatic drain(input int d, input int ch,
                       input int n, input int budget);
    int got;
    int t;
    logic v;
    logic [8:0] obs;
    logic [9:0] e;
    got = 0;
    t = 0;
    while (got < n) begin
      @(negedge clk);
      if (d == 0) begin
        v   = b0.o_ch_byte_vld[ch];
        obs = {b0.o_ch_last_byte[ch], b0.o_ch_byte[8*ch +: 8]};
        b0.i_ch_byte_rd[ch] = v;
      end else begin
        v   = b1.o_ch_byte_vld[ch];
        obs = {b1.o_ch_last_byte[ch], b1.o_ch_byte[8*ch +: 8]};
        b1.i_ch_byte_rd[ch] = v;
      end
      if (v) begin
        e = pop_exp(d, ch);
        checks++;
        if (!e[9]) begin
          errors++;
          $display("FAIL drain_extra d%0d ch%0d: got %h want none",
                   d, ch, obs);
        end else if (obs !== e[8:0]) begin
          errors++;
          $display("FAIL drain d%0d ch%0d #%0d: got %h want %h",
                   d, ch, got, obs, e[8:0]);
        end
        got++;
      end
      t++;
      if (t > budget) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout d%0d ch%0d: got %0d want %0d",
                 d, ch, got, n);
        break;
      end
    end
    @(negedge clk);
    b0.i_ch_byte_rd = '0;
    b1.i_ch_byte_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    q00.delete();
    q01.delete();
    q11.delete();
  endtask

  task automatic test_reset();
    logic [40:0] o0, o1;
    @(negedge clk);
    srst = 1'b1;
    repeat (3) @(negedge clk);
    o0 = {b0.o_ipv4_pkt_byte_rd, b0.o_ch_byte,
          b0.o_ch_byte_vld, b0.o_ch_last_byte,
          ovf0, uns0, mal0, drop0};
    o1 = {b1.o_ipv4_pkt_byte_rd, b1.o_ch_byte,
          b1.o_ch_byte_vld, b1.o_ch_last_byte,
          ovf1, uns1, mal1, drop1};
    checks++;
    if (o0 !== '0) begin
      errors++;
      $display("FAIL reset_dut0: got %h want 0", o0);
    end
    checks++;
    if (o1 !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got %h want 0", o1);
    end
    srst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int vcyc;
    int m0, u0;
    m0 = mal_n;
    u0 = uns_n;
    vcyc = -1;
    build(8'h11, 5, 28);
    expect_pkt(0, 0, 20);
    mark_idx = 20;
    fork
      send(0, 500);
      begin
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (b0.o_ch_byte_vld[0]) begin
            vcyc = cyc;
            break;
          end
        end
      end
    join
    mark_idx = -1;
    checks++;
    if (vcyc - mark_cyc != 2) begin
      errors++;
      $display("FAIL write_latency: got %0d want 2",
               vcyc - mark_cyc);
    end
    build(8'h11, 5, 28);
    expect_pkt(0, 0, 20);
    send(0, 500);
    drain(0, 0, 16, 500);
    repeat (4) @(negedge clk);
    checks++;
    if (b0.o_ch_byte_vld !== 2'b00 || q00.size() != 0) begin
      errors++;
      $display("FAIL b2b_residue: vld %b left %0d want 00 0",
               b0.o_ch_byte_vld, q00.size());
    end
    checks++;
    if (drop0 !== 16'd0 || mal_n != m0 || uns_n != u0) begin
      errors++;
      $display("FAIL b2b_errs: drop %0d pulses %0d want 0 0",
               drop0, mal_n - m0 + uns_n - u0);
    end
  endtask

  task automatic test_icmp_ihl6();
    build(8'h01, 6, 40);
    expect_pkt(0, 1, 24);
    send(0, 500);
    drain(0, 1, 16, 500);
    checks++;
    if (b0.o_ch_byte_vld !== 2'b00) begin
      errors++;
      $display("FAIL strip_residue: vld %b want 00",
               b0.o_ch_byte_vld);
    end
    expect_pkt(1, 1, 0);
    send(1, 500);
    drain(1, 1, 40, 500);
    checks++;
    if (b1.o_ch_byte_vld !== 2'b00 || drop1 !== 16'd0) begin
      errors++;
      $display("FAIL keep_residue: vld %b drop %0d want 00 0",
               b1.o_ch_byte_vld, drop1);
    end
  endtask

  task automatic test_unsupported();
    int m0, u0;
    m0 = mal_n;
    u0 = uns_n;
    build(8'h06, 5, 60);
    send(0, 500);
    build(8'h11, 5, 28);
    expect_pkt(0, 0, 20);
    send(0, 500);
    drain(0, 0, 8, 500);
    repeat (4) @(negedge clk);
    checks++;
    if (uns_n - u0 != 1 || mal_n != m0) begin
      errors++;
      $display("FAIL unsup_pulse: uns %0d mal %0d want 1 0",
               uns_n - u0, mal_n - m0);
    end
    checks++;
    if (drop0 !== 16'd1 || b0.o_ch_byte_vld !== 2'b00) begin
      errors++;
      $display("FAIL unsup_drop: drop %0d vld %b want 1 00",
               drop0, b0.o_ch_byte_vld);
    end
  endtask

  task automatic test_malformed();
    int m0, u0;
    do_reset();
    m0 = mal_n;
    u0 = uns_n;
    build(8'h11, 4, 30);
    send(0, 500);
    repeat (3) @(negedge clk);
    checks++;
    if (mal_n - m0 != 1) begin
      errors++;
      $display("FAIL ihl4_pulse: got %0d want 1", mal_n - m0);
    end
    build(8'h11, 5, 28);
    while (pkt.size() > 13) void'(pkt.pop_back());
    send(0, 500);
    repeat (3) @(negedge clk);
    checks++;
    if (mal_n - m0 != 2 || uns_n != u0 || drop0 !== 16'd2)
    begin
      errors++;
      $display("FAIL trunc: mal %0d uns %0d drop %0d want 2 0 2",
               mal_n - m0, uns_n - u0, drop0);
    end
    build(8'h11, 5, 20);
    send(0, 500);
    repeat (3) @(negedge clk);
    checks++;
    if (mal_n - m0 != 3 || drop0 !== 16'd3) begin
      errors++;
      $display("FAIL empty_payload: mal %0d drop %0d want 3 3",
               mal_n - m0, drop0);
    end
    checks++;
    if (b0.o_ch_byte_vld !== 2'b00) begin
      errors++;
      $display("FAIL malformed_write: vld %b want 00",
               b0.o_ch_byte_vld);
    end
  endtask

  task automatic test_wait_space();
    logic [15:0] d0;
    d0 = drop0;
    sent_cnt = 0;
    fork
      begin
        for (int p = 0; p < 3; p++) begin
          build(8'h11, 5, 1500);
          expect_pkt(0, 0, 20);
          send(0, 20000);
          sent_cnt++;
        end
      end
      begin
        for (int t = 0; t < 5000; t++) begin
          @(negedge clk);
          if (sent_cnt == 1 && send_idx == 20) break;
        end
        repeat (50) @(negedge clk);
        checks++;
        if (b0.o_ipv4_pkt_byte_rd !== 1'b0 ||
            send_idx != 20 || sent_cnt != 1) begin
          errors++;
          $display("FAIL wait_space: rd %b idx %0d pk %0d want 0 20 1",
                   b0.o_ipv4_pkt_byte_rd, send_idx, sent_cnt);
        end
        drain(0, 0, 3 * 1480, 30000);
      end
    join
    checks++;
    if (ovf0 !== 2'b00 || q00.size() != 0 || drop0 !== d0)
    begin
      errors++;
      $display("FAIL wait_space_end: ovf %b left %0d drop %0d",
               ovf0, q00.size(), drop0);
    end
  endtask

  task automatic test_reset_mid_route();
    logic [40:0] o0;
    build(8'h11, 5, 200);
    expect_pkt(0, 0, 20);
    fork
      send(0, 2000);
      begin
        for (int t = 0; t < 500; t++) begin
          @(negedge clk);
          if (send_idx >= 60) break;
        end
        srst = 1'b1;
        abort_tx = 1'b1;
        @(negedge clk);
        o0 = {b0.o_ipv4_pkt_byte_rd, b0.o_ch_byte,
              b0.o_ch_byte_vld, b0.o_ch_last_byte,
              ovf0, uns0, mal0, drop0};
        checks++;
        if (o0 !== '0) begin
          errors++;
          $display("FAIL mid_reset: got %h want 0", o0);
        end
      end
    join
    @(negedge clk);
    srst = 1'b0;
    abort_tx = 1'b0;
    q00.delete();
    build(8'h11, 5, 28);
    expect_pkt(0, 0, 20);
    send(0, 500);
    drain(0, 0, 8, 500);
    checks++;
    if (b0.o_ch_byte_vld !== 2'b00 || drop0 !== 16'd0) begin
      errors++;
      $display("FAIL post_reset: vld %b drop %0d want 00 0",
               b0.o_ch_byte_vld, drop0);
    end
  endtask

  initial begin
    srst = 1'b1;
    b0.i_ipv4_pkt_byte      = '0;
    b0.i_ipv4_pkt_byte_vld  = 1'b0;
    b0.i_ipv4_pkt_last_byte = 1'b0;
    b0.i_ch_byte_rd         = '0;
    b1.i_ipv4_pkt_byte      = '0;
    b1.i_ipv4_pkt_byte_vld  = 1'b0;
    b1.i_ipv4_pkt_last_byte = 1'b0;
    b1.i_ch_byte_rd         = '0;
    test_reset();
    test_back_to_back();
    test_icmp_ihl6();
    test_unsupported();
    test_malformed();
    test_wait_space();
    test_reset_mid_route();
    checks++;
    if (both_n != 0) begin
      errors++;
      $display("FAIL coincident_pulses: got %0d want 0", both_n);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
